// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master pipelined Wishbone arbiter
// with outstanding-ack tracking and a bus watchdog.
module wb_arbiter2 #(
    parameter int PRIO_RR = 0,
    parameter int TIMEOUT = 255,
    parameter int MAX_OUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_stall_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_stall_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_stall_i,
    output logic [1:0]  grant_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_G0   = 2'd1;
    localparam logic [1:0] S_G1   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic [9:0]  watchdog_q, watchdog_d;
    logic        last_q, last_d;

    logic        owned, own1, own_cyc, own_stb, own_we;
    logic        other_cyc;
    logic [31:0] own_adr, own_dat;
    logic [3:0]  own_sel;
    logic        full, fire, ack_ok, accept;

    // Pick the owning master's request and derive bus qualifiers
    always_comb begin
        owned     = (state_q == S_G0) || (state_q == S_G1);
        own1      = (state_q == S_G1);
        own_cyc   = own1 ? m1_cyc_i : m0_cyc_i;
        own_stb   = own1 ? m1_stb_i : m0_stb_i;
        own_we    = own1 ? m1_we_i  : m0_we_i;
        own_adr   = own1 ? m1_adr_i : m0_adr_i;
        own_sel   = own1 ? m1_sel_i : m0_sel_i;
        own_dat   = own1 ? m1_dat_i : m0_dat_i;
        other_cyc = own1 ? m0_cyc_i : m1_cyc_i;
        full      = (outstanding_q == 4'(MAX_OUT));
        fire      = owned && (outstanding_q != 4'd0) && !s_ack_i
                    && (watchdog_q == 10'(TIMEOUT - 1));
        ack_ok    = owned && s_ack_i && (outstanding_q != 4'd0);
    end

    // Route owner to slave; non-owner sees stall and nothing else
    always_comb begin
        s_cyc_o    = owned & own_cyc & ~fire;
        s_stb_o    = owned & own_cyc & own_stb & ~full & ~fire;
        s_we_o     = owned & own_we;
        s_adr_o    = owned ? own_adr : 32'd0;
        s_sel_o    = owned ? own_sel : 4'd0;
        s_dat_o    = owned ? own_dat : 32'd0;
        accept     = s_stb_o & ~s_stall_i;
        m0_dat_o   = (state_q == S_G0) ? s_dat_i : 32'd0;
        m0_ack_o   = (state_q == S_G0) & ack_ok;
        m0_err_o   = (state_q == S_G0) & fire;
        m0_stall_o = (state_q != S_G0) | s_stall_i | full | fire;
        m1_dat_o   = own1 ? s_dat_i : 32'd0;
        m1_ack_o   = own1 & ack_ok;
        m1_err_o   = own1 & fire;
        m1_stall_o = ~own1 | s_stall_i | full | fire;
        grant_o    = {own1, state_q == S_G0};
    end

    // Arbitration, release, outstanding count and watchdog
    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        watchdog_d    = watchdog_q;
        last_d        = last_q;
        unique case (state_q)
            S_IDLE: begin
                outstanding_d = 4'd0;
                watchdog_d    = 10'd0;
                if (m0_cyc_i && m1_cyc_i) begin
                    if (PRIO_RR != 0 && last_q) state_d = S_G0;
                    else state_d = S_G1;
                end else if (m1_cyc_i) begin
                    state_d = S_G1;
                end else if (m0_cyc_i) begin
                    state_d = S_G0;
                end
            end
            S_G0, S_G1: begin
                if (!own_cyc) begin
                    last_d        = own1;
                    outstanding_d = 4'd0;
                    watchdog_d    = 10'd0;
                    if (other_cyc) state_d = own1 ? S_G0 : S_G1;
                    else state_d = S_IDLE;
                end else if (fire) begin
                    outstanding_d = 4'd0;
                    watchdog_d    = 10'd0;
                end else begin
                    outstanding_d = outstanding_q
                                  + {3'b000, accept}
                                  - {3'b000, ack_ok};
                    if (s_ack_i || outstanding_q == 4'd0)
                        watchdog_d = 10'd0;
                    else
                        watchdog_d = watchdog_q + 10'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            outstanding_q <= 4'd0;
            watchdog_q    <= 10'd0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            watchdog_q    <= watchdog_d;
            last_q        <= last_d;
        end
    end

endmodule
